// File: rtl/burst_gen.sv
// rtl/burst_gen.sv - chip-select framed address burst generator
// Outputs are registered from the current state, so they trail the FSM by one cycle.
module burst_gen #(
  parameter int AW    = 5,
  parameter int LW    = 5,
  parameter int SYNC  = 2,
  parameter int SETUP = 4,
  parameter int HOLD  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          abort,
  output logic          csn,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] addr,
  output logic [LW-1:0] st,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CS0  = 3'd1,
    DATA = 3'd2,
    CS1  = 3'd3,
    REDY = 3'd4
  } state_t;

  state_t        state;
  logic [LW-1:0] cnt;
  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_next;
  logic          req_s;
  logic          wr_l;
  logic [AW-1:0] base_l;
  logic [LW-1:0] len_l;
  logic          first;
  logic          beat;

  always_comb begin
    sync_next    = sync_q << 1;
    sync_next[0] = req;
  end

  assign req_s = sync_q[SYNC-1];
  assign st    = cnt;

  // An abort seen during DATA suppresses the strobe that would otherwise follow.
  assign beat = (state == DATA) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sync_q <= '0;
      wr_l   <= 1'b0;
      base_l <= '0;
      len_l  <= '0;
      first  <= 1'b0;
      csn    <= 1'b1;
      we     <= 1'b0;
      re     <= 1'b0;
      addr   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      sync_q <= sync_next;

      csn  <= !((state == CS0) || (state == DATA));
      we   <= beat && wr_l;
      re   <= beat && !wr_l;
      busy <= (state == CS0) || (state == DATA) || (state == CS1);
      done <= (state == REDY) && first;
      if (beat) begin
        addr <= base_l + AW'(cnt);
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_s) begin
            wr_l   <= wr;
            base_l <= base;
            len_l  <= len;
            state  <= CS0;
          end
        end
        CS0: begin
          if (abort) begin
            cnt   <= '0;
            state <= CS1;
          end else if (cnt == LW'(SETUP - 1)) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        DATA: begin
          if (abort || (cnt == len_l)) begin
            cnt   <= '0;
            state <= CS1;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        CS1: begin
          if (cnt == LW'(HOLD - 1)) begin
            cnt   <= '0;
            first <= 1'b1;
            state <= REDY;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        REDY: begin
          cnt   <= '0;
          first <= 1'b0;
          if (!req_s) begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          first <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_gen.sv
// tb/tb_burst_gen.sv - directed vector bench for burst_gen
module tb_burst_gen;

  localparam int AW = 5;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          req2;
  logic          wr;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          abort;

  logic          csn, we, re, busy, done;
  logic [AW-1:0] addr;
  logic [LW-1:0] st;
  logic          csn2, we2, re2, busy2, done2;
  logic [AW-1:0] addr2;
  logic [LW-1:0] st2;

  always #5 clk = ~clk;

  burst_gen dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .base(base), .len(len), .abort(abort),
    .csn(csn), .we(we), .re(re), .addr(addr), .st(st), .busy(busy), .done(done)
  );

  burst_gen #(.AW(AW), .LW(LW), .SYNC(3), .SETUP(1), .HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wr(wr), .base(base), .len(len), .abort(abort),
    .csn(csn2), .we(we2), .re(re2), .addr(addr2), .st(st2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] b;
    logic [LW-1:0] l;
    int            abort_beat;
    int            exp_csn;
    int            exp_beats;
    int            exp_last;
    int            exp_hold;
  } vec_t;

  vec_t vecs[5];
  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int beats[$];
    int n_csn, n_we, n_re, n_hold, cyc, lat, slat, extra_csn, extra_done;
    bit done_seen, done_busy;
    n_csn = 0; n_we = 0; n_re = 0; n_hold = 0; cyc = 0; lat = -1; slat = -1;
    done_seen = 0; done_busy = 1;
    @(negedge clk);
    wr = v.w; base = v.b; len = v.l; req = 1'b1;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      if (!csn && lat < 0) lat = cyc;
      if ((we || re) && slat < 0) slat = cyc;
      if (!csn) n_csn++;
      if (we) n_we++;
      if (re) n_re++;
      if (we || re) beats.push_back(int'(addr));
      if (csn && busy) n_hold++;
      if (done) begin
        done_seen = 1;
        done_busy = busy;
      end
      // Latched fields must be immune to input changes mid-burst.
      if (!csn) begin
        wr = ~v.w; base = ~v.b; len = ~v.l;
      end
      if (v.abort_beat >= 0 && (we || re) && beats.size() == v.abort_beat + 1) abort = 1'b1;
    end
    abort = 1'b0;
    check($sformatf("v%0d_done_seen", idx), int'(done_seen), 1);
    check($sformatf("v%0d_done_busy", idx), int'(done_busy), 0);
    check($sformatf("v%0d_csn_latency", idx), lat, 4);
    check($sformatf("v%0d_strobe_latency", idx), slat, 8);
    if (v.exp_csn >= 0) check($sformatf("v%0d_csn_low", idx), n_csn, v.exp_csn);
    check($sformatf("v%0d_we_cnt", idx), n_we, v.w ? v.exp_beats : 0);
    check($sformatf("v%0d_re_cnt", idx), n_re, v.w ? 0 : v.exp_beats);
    check($sformatf("v%0d_hold", idx), n_hold, v.exp_hold);
    if (beats.size() > 0) check($sformatf("v%0d_last_addr", idx), beats[beats.size()-1], v.exp_last);
    for (int i = 0; i < beats.size(); i++)
      check($sformatf("v%0d_addr%0d", idx, i), beats[i], (int'(v.b) + i) % 32);
    // req stays high: REDY must not start another burst.
    extra_csn = 0; extra_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (!csn) extra_csn++;
      if (done || busy) extra_done++;
    end
    check($sformatf("v%0d_no_restart_csn", idx), extra_csn, 0);
    check($sformatf("v%0d_no_restart_done", idx), extra_done, 0);
    req = 1'b0;
    wr = 1'b0; base = '0; len = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int cyc, lat, slat, n_st, n_hold, last;
    bit hit, done_seen;
    vecs[0] = '{1'b1, 5'd0,  5'd19, -1, 24, 20, 19, 4};
    vecs[1] = '{1'b0, 5'd30, 5'd3,  -1,  8,  4,  1, 4};
    vecs[2] = '{1'b1, 5'd0,  5'd19,  5, -1,  6,  5, 4};
    vecs[3] = '{1'b1, 5'd10, 5'd0,  -1,  5,  1, 10, 4};
    vecs[4] = '{1'b0, 5'd31, 5'd1,  -1,  6,  2,  0, 4};

    rst = 1'b0; req = 1'b0; req2 = 1'b0; wr = 1'b0; base = '0; len = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_csn", int'(csn), 1);
    check("rst_strobes", int'({we, re}), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_busy_done", int'({busy, done}), 0);
    check("rst_st", int'(st), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of DATA.
    @(negedge clk);
    wr = 1'b1; base = '0; len = 5'd19; req = 1'b1;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (we && addr == 5'd3) hit = 1;
    end
    check("mid_reset_reached_beat3", int'(hit), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_csn", int'(csn), 1);
    check("mid_reset_strobes", int'({we, re}), 0);
    check("mid_reset_addr", int'(addr), 0);
    check("mid_reset_busy_done", int'({busy, done}), 0);
    check("mid_reset_st", int'(st), 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_st = 0;
    repeat (6) begin
      @(negedge clk);
      if (!csn || busy) n_st++;
    end
    check("post_reset_idle", n_st, 0);
    run_vec(5, vecs[3]);

    // SYNC=3, SETUP=1, HOLD=1 single-beat burst on the second instance.
    @(negedge clk);
    wr = 1'b1; base = 5'd7; len = '0; req2 = 1'b1;
    cyc = 0; lat = -1; slat = -1; n_st = 0; n_hold = 0; last = -1; done_seen = 0;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!csn2 && lat < 0) lat = cyc;
      if (we2 && slat < 0) slat = cyc;
      if (we2) begin
        n_st++;
        last = int'(addr2);
      end
      if (csn2 && busy2) n_hold++;
      if (done2) done_seen = 1;
    end
    check("s3_done_seen", int'(done_seen), 1);
    check("s3_csn_latency", lat, 5);
    check("s3_strobe_latency", slat, 6);
    check("s3_beats", n_st, 1);
    check("s3_addr", last, 7);
    check("s3_hold", n_hold, 1);
    req2 = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/burst_gen.md
BURST_GEN -- requirements
Module: burst_gen

Parameters
REQ-001 AW, default 5: address width; addr and base are AW bits.
REQ-002 LW, default 5: length/counter width; len and st are LW bits.
REQ-003 SYNC, default 2 (legal 1..4): req synchroniser stages.
REQ-004 SETUP, default 4 (legal 1..2^LW): cycles of csn-low setup before the first data beat.
REQ-005 HOLD, default 4 (legal 1..2^LW): csn-high recovery cycles after the last beat.

Interface
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-008 req  in  1  asynchronous burst request, level; synchronised internally.
REQ-009 wr  in  1  mode: 1 = write burst (we), 0 = read burst (re); sampled at burst start.
REQ-010 base  in  AW  start address; sampled at burst start.
REQ-011 len  in  LW  beat count minus one (0 = 1 beat); sampled at burst start.
REQ-012 abort  in  1  synchronous; cuts the burst short.
REQ-013 csn  out  1  chip select, active low, registered.
REQ-014 we / re  out  1 each  write / read strobe, registered, mutually exclusive.
REQ-015 addr  out  AW  beat address, registered; holds its last value outside DATA.
REQ-016 st  out  LW  internal phase counter value.
REQ-017 busy / done  out  1 each  busy = burst in progress; done = 1-cycle completion pulse.

Function
REQ-018 States: IDLE, CS0 (setup), DATA, CS1 (hold), REDY.
REQ-019 req_s is the last stage of a SYNC-deep shift register, reset to 0.
REQ-020 IDLE: on req_s=1, latch wr, base and len; go to CS0.
REQ-021 CS0: cnt increments each cycle; after SETUP cycles, cnt clears and the FSM goes to DATA.
REQ-022 DATA: beat i (i = 0..len) drives addr = base + i mod 2^AW, wrapping silently.
REQ-023 DATA: we=1 when the latched wr=1, otherwise re=1.
REQ-024 DATA: after len+1 beats, cnt clears and the FSM goes to CS1.
REQ-025 CS1: csn=1; after HOLD cycles, cnt clears and the FSM goes to REDY.
REQ-026 REDY: done=1 for exactly its first cycle; return to IDLE when req_s=0.
REQ-027 REDY: while req_s stays 1, no new burst starts (one burst per req level).
REQ-028 csn=0 in CS0 and DATA only; we=re=0 outside DATA; cnt=0 in IDLE and REDY.
REQ-029 busy=1 in CS0, DATA and CS1.
REQ-030 Latency: req first sampled high at edge k gives csn=0 after edge k+SYNC+1.
REQ-031 Strobe and address output: first strobe/addr after edge k+SYNC+1+SETUP.
REQ-032 abort in CS0 or DATA: the next state is CS1.
REQ-033 abort in DATA: the strobe is deasserted from the next cycle; the current beat completes and no further beats are issued.
REQ-034 abort in IDLE, CS1 or REDY: ignored.
REQ-035 abort and the phase-end condition in the same cycle: same result (go to CS1).
REQ-036 wr, base and len changes during a burst: no effect until the next IDLE start.
REQ-037 Illegal state encoding: recover to IDLE on the next edge.

Reset
REQ-038 rst=0 at any time, including mid-burst: state IDLE, csn=1, we=re=0, addr=0, st=0, busy=0, done=0, sync register 0.
REQ-039 After rst releases, no burst starts until req_s rises from the cleared synchroniser.

Verification
REQ-040 Defaults, wr=1, base=0, len=19, req held high:
  - csn low for 24 cycles;
  - we high for 20 cycles with addr 0..19;
  - then 4 csn-high cycles, done pulse, busy low.
REQ-041 wr=0, base=30, len=3: re high for 4 cycles with addr 30, 31, 0, 1 (wrap); we stays 0.
REQ-042 abort asserted during beat 5 of a len=19 write:
  - only beats 0..5 are issued (addr 0..5);
  - strobe low from the next cycle;
  - 4 hold cycles, then done.
REQ-043 req held high through REDY for 10 cycles:
  - exactly one burst;
  - after req drops, a new req starts a second burst with the freshly sampled base/len.
REQ-044 rst pulsed low during DATA:
  - all outputs are at reset values immediately (asynchronously);
  - a subsequent req runs a complete normal burst.
REQ-045 SYNC=3, SETUP=1, HOLD=1, len=0:
  - csn falls after edge k+4;
  - a single strobe cycle;
  - one hold cycle, then done.
